// File: rtl/spi_frame_arbiter.sv
// rtl/spi_frame_arbiter.sv - two-requester round-robin frame arbiter in front of an SPI byte master
// Optional WAIT_END timeout abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_frame_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        m_have_data,
    output logic [7:0]  m_data,
    input  logic        m_rdreq,
    input  logic        m_wrreq,
    input  logic [7:0]  m_miso,
    input  logic        m_io_update,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_id,
    output logic        done,
    output logic        done_id,
    output logic [7:0]  done_bytes,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, GRANT, STREAM, WAIT_END, DONE} state_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic       io_q;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       io_rise, fwd, pop, sel_valid, sel_last;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    assign io_rise   = m_io_update & ~io_q;
    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        fwd         = 1'b0;
        pop         = 1'b0;
        m_have_data = 1'b0;
        m_data      = 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d       = 32'd0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = req_valid[ptr_q] ? ptr_q : ~ptr_q;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = 8'h00;
                state_d = STREAM;
            end
            STREAM: begin
                fwd         = 1'b1;
                m_have_data = sel_valid;
                m_data      = grant_q ? req_data[15:8] : req_data[7:0];
                pop         = m_rdreq & sel_valid;
                // An end-of-frame before the last byte means the requester ran dry.
                if (io_rise) begin
                    err_d   = 1'b1;
                    ptr_d   = ~grant_q;
                    state_d = IDLE;
                end else if (pop & sel_last) begin
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                fwd = 1'b1;
                if (io_rise) begin
                    state_d = DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYC - 32'd1) begin
                    err_d   = 1'b1;
                    ptr_d   = ~grant_q;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            DONE: begin
                ptr_d   = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rx_valid_d = fwd & m_wrreq;
        rx_data_d  = rx_valid_d ? m_miso : 8'h00;
        if (rx_valid_d && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign req_ready  = grant_q ? {pop, 1'b0} : {1'b0, pop};
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_id      = grant_q;
    assign done       = (state_q == DONE);
    assign done_id    = done & grant_q;
    assign done_bytes = done ? cnt_q : 8'h00;
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            ptr_q      <= 1'b0;
            io_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            cnt_q      <= 8'h00;
            err_q      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            io_q       <= m_io_update;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// tb/tb_spi_frame_arbiter.sv - scoreboard bench for spi_frame_arbiter with a behavioural SPI master
module tb_spi_frame_arbiter;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [15:0] req_data;
    logic        m_have_data, m_rdreq, m_wrreq, m_io_update;
    logic [7:0]  m_data, m_miso;
    logic        rx_valid, rx_id, done, done_id, err;
    logic [7:0]  rx_data, done_bytes;

    spi_frame_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .m_have_data(m_have_data), .m_data(m_data), .m_rdreq(m_rdreq),
        .m_wrreq(m_wrreq), .m_miso(m_miso), .m_io_update(m_io_update),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id),
        .done(done), .done_id(done_id), .done_bytes(done_bytes), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; bit last; logic [7:0] echo; int extra; } item_t;
    typedef struct { bit id; logic [7:0] d; } exp_t;
    typedef struct { bit id; logic [7:0] n; } done_t;
    typedef struct { bit id; int n; logic [23:0] tx; logic [23:0] ech; int extra; logic [7:0] exp_bytes; } vec_t;

    item_t rq0[$], rq1[$];
    exp_t  exp_tx[$], exp_rx[$];
    done_t exp_done[$];
    vec_t  tbl[5];
    int    exp_err_n = 0;
    int    checks = 0, errors = 0;
    int    cyc = 0, err_cnt = 0, err_cyc = 0, pop_cyc = 0, err_before;

    bit    rd_en = 1, auto_end = 1, in_frame = 0, last_seen = 0, popped = 0, cur_id = 0;
    int    extra_left = 0, idle_cnt = 0, io_cnt = 0;
    item_t pop_item;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic load(input bit id, input int n, input logic [23:0] tx, input logic [23:0] ech,
                        input int extra, input bit end_last);
        item_t it;
        for (int k = 0; k < n; k++) begin
            it.d     = tx[8*k +: 8];
            it.echo  = ech[8*k +: 8];
            it.last  = end_last && (k == n - 1);
            it.extra = extra;
            if (id) rq1.push_back(it); else rq0.push_back(it);
            exp_tx.push_back('{id, it.d});
        end
    endtask

    task automatic drive_reqs();
        req_valid = {rq1.size() > 0, rq0.size() > 0};
        req_data  = {(rq1.size() > 0) ? rq1[0].d : 8'h00, (rq0.size() > 0) ? rq0[0].d : 8'h00};
        req_last  = {(rq1.size() > 0) ? rq1[0].last : 1'b0, (rq0.size() > 0) ? rq0[0].last : 1'b0};
    endtask

    task automatic sample();
        exp_t  e;
        done_t d;
        popped = 0;
        if (req_ready != 2'b00 || (m_rdreq && m_have_data)) begin
            chk("pop_vs_have", {31'd0, |req_ready}, {31'd0, m_rdreq & m_have_data});
            if (exp_tx.size() == 0) begin
                chk("tx_unexpected", {30'd0, req_ready}, 32'd0);
            end else begin
                e = exp_tx.pop_front();
                chk("tx_ready", {30'd0, req_ready}, e.id ? 32'd2 : 32'd1);
                chk("tx_data", {24'd0, m_data}, {24'd0, e.d});
                if (e.id && rq1.size() > 0) pop_item = rq1.pop_front();
                else if (!e.id && rq0.size() > 0) pop_item = rq0.pop_front();
                popped   = 1;
                cur_id   = e.id;
                in_frame = 1;
                idle_cnt = 0;
                pop_cyc  = cyc;
                if (pop_item.last) begin
                    last_seen  = 1;
                    extra_left = pop_item.extra;
                end
            end
        end
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                chk("rx_unexpected", {31'd0, rx_valid}, 32'd0);
            end else begin
                e = exp_rx.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                chk("rx_id", {31'd0, rx_id}, {31'd0, e.id});
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                d = exp_done.pop_front();
                chk("done_id", {31'd0, done_id}, {31'd0, d.id});
                chk("done_bytes", {24'd0, done_bytes}, {24'd0, d.n});
            end
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            if (exp_err_n == 0) chk("err_unexpected", {31'd0, err}, 32'd0);
            else exp_err_n--;
            in_frame   = 0;
            last_seen  = 0;
            extra_left = 0;
        end
        if (in_frame && !last_seen && !popped && !m_have_data) idle_cnt++;
    endtask

    task automatic drive();
        m_wrreq = 1'b0;
        m_miso  = 8'h00;
        if (popped) begin
            m_wrreq = 1'b1;
            m_miso  = pop_item.echo;
            exp_rx.push_back('{cur_id, pop_item.echo});
        end else if (last_seen && extra_left > 0) begin
            m_wrreq = 1'b1;
            m_miso  = 8'(extra_left);
            exp_rx.push_back('{cur_id, 8'(extra_left)});
            extra_left--;
        end
        if (io_cnt > 0) begin
            io_cnt--;
        end else if (in_frame && !m_wrreq) begin
            if (last_seen && extra_left == 0 && auto_end) begin
                io_cnt = 2; in_frame = 0; last_seen = 0;
            end else if (!last_seen && idle_cnt >= 4) begin
                io_cnt = 2; in_frame = 0;
            end
        end
        m_io_update = (io_cnt > 0);
        m_rdreq     = rd_en;
        drive_reqs();
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while ((exp_tx.size() > 0 || exp_rx.size() > 0 || exp_done.size() > 0 || exp_err_n > 0 ||
                in_frame || io_cnt > 0 || rq0.size() > 0 || rq1.size() > 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles expected=<%0d", nm, k, budget);
        end
        repeat (2) step();
    endtask

    task automatic flush();
        rq0.delete(); rq1.delete(); exp_tx.delete(); exp_rx.delete(); exp_done.delete();
        exp_err_n = 0; in_frame = 0; last_seen = 0; popped = 0; extra_left = 0;
        idle_cnt = 0; io_cnt = 0;
        drive();
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog actual=%0d cycles expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; m_rdreq = 1'b0; m_wrreq = 1'b0; m_miso = 8'h00; m_io_update = 1'b0;
        req_valid = 2'b00; req_data = 16'h0000; req_last = 2'b00;

        tbl[0] = '{id: 1'b0, n: 2, tx: 24'h003CA5, ech: 24'h002211, extra: 0, exp_bytes: 8'd2};
        tbl[1] = '{id: 1'b0, n: 1, tx: 24'h0000E7, ech: 24'h00007E, extra: 0, exp_bytes: 8'd1};
        tbl[2] = '{id: 1'b1, n: 3, tx: 24'h030201, ech: 24'hC0B0A0, extra: 0, exp_bytes: 8'd3};
`ifdef SPI_ARB_TIMEOUT_EN
        tbl[3] = '{id: 1'b0, n: 1, tx: 24'h000055, ech: 24'h0000AA, extra: 10, exp_bytes: 8'd11};
`else
        tbl[3] = '{id: 1'b0, n: 1, tx: 24'h000055, ech: 24'h0000AA, extra: 299, exp_bytes: 8'd255};
`endif
        tbl[4] = '{id: 1'b1, n: 3, tx: 24'h99F00F, ech: 24'h123456, extra: 2, exp_bytes: 8'd5};

        @(negedge clk);
        chk("reset_outputs", {req_ready, m_have_data, m_data, rx_valid, rx_data, rx_id,
                              done, done_id, done_bytes, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive();

        // Simultaneous requests twice: req0 first both times.
        load(0, 2, 24'h002010, 24'h00B1A1, 0, 1);
        load(1, 2, 24'h004030, 24'h00D1C1, 0, 1);
        exp_done.push_back('{1'b0, 8'd2});
        exp_done.push_back('{1'b1, 8'd2});
        wait_idle(200, "rr_first");
        load(0, 1, 24'h000050, 24'h0000E1, 0, 1);
        load(1, 1, 24'h000060, 24'h0000F1, 0, 1);
        exp_done.push_back('{1'b0, 8'd1});
        exp_done.push_back('{1'b1, 8'd1});
        wait_idle(200, "rr_second");

        for (int i = 0; i < 5; i++) begin
            load(tbl[i].id, tbl[i].n, tbl[i].tx, tbl[i].ech, tbl[i].extra, 1);
            exp_done.push_back('{tbl[i].id, tbl[i].exp_bytes});
            wait_idle(800, "table_frame");
        end

        // req1 shows up mid-frame and must wait for req0's done.
        load(0, 3, 24'h0C0B0A, 24'h1C1B1A, 0, 1);
        step(); step();
        load(1, 2, 24'h000E0D, 24'h001E1D, 0, 1);
        exp_done.push_back('{1'b0, 8'd3});
        exp_done.push_back('{1'b1, 8'd2});
        wait_idle(200, "late_req1");

        // req0 underflows after one byte: err, then req1 served.
        load(0, 1, 24'h0000A1, 24'h0000B2, 0, 0);
        load(1, 2, 24'h00C4C3, 24'h00D4D3, 0, 1);
        exp_err_n = 1;
        exp_done.push_back('{1'b1, 8'd2});
        err_before = err_cnt;
        wait_idle(200, "underflow");
        chk("underflow_err_count", err_cnt - err_before, 32'd1);

        // io_update pulse while idle is ignored.
        err_before = err_cnt;
        io_cnt = 3;
        wait_idle(20, "io_idle");
        chk("io_idle_no_err", err_cnt - err_before, 32'd0);

        // WAIT_END with no end-of-frame from the master.
        auto_end = 0;
        err_before = err_cnt;
        load(0, 1, 24'h00005A, 24'h0000A5, 0, 1);
`ifdef SPI_ARB_TIMEOUT_EN
        exp_err_n = 1;
        wait_idle(200, "timeout_abort");
        chk("timeout_latency", err_cyc - pop_cyc, TMO + 1);
        chk("timeout_err_count", err_cnt - err_before, 32'd1);
        auto_end = 1;
`else
        repeat (40) step();
        chk("no_timeout_err", err_cnt - err_before, 32'd0);
        chk("wait_end_no_data", {31'd0, m_have_data}, 32'd0);
        auto_end = 1;
        exp_done.push_back('{1'b0, 8'd1});
        wait_idle(100, "late_end");
`endif

        // Reset in the middle of STREAM.
        rd_en = 0;
        load(0, 3, 24'h333231, 24'h434241, 0, 1);
        drive();
        step(); step();
        @(negedge clk);
        chk("stream_have_data", {31'd0, m_have_data}, 32'd1);
        chk("stream_data", {24'd0, m_data}, 32'h31);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_mid_outputs", {req_ready, m_have_data, m_data, rx_valid, rx_data, rx_id,
                                  done, done_id, done_bytes, err}, 32'd0);
        err_before = err_cnt;
        rd_en = 1;
        flush();
        step(); step();
        rst = 1'b1;
        load(0, 2, 24'h007776, 24'h008786, 0, 1);
        exp_done.push_back('{1'b0, 8'd2});
        wait_idle(200, "after_reset");
        chk("after_reset_no_err", err_cnt - err_before, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
